series_ctrl: RTL and testbench

- FSM controller that sequences the fixed-point series-evaluation datapath: multiplier, add/sub unit, and the x, tmp, ans and y registers.
- Computes ans = 1 + Σ c[i]·x^(i+1) for i = 0..TERMS-1, with optional alternating sign and optional early exit when a term drops below threshold y.
- Sits between a start/done requester and the datapath. Drives every datapath select/load line; reads back less_cmp.

---
 rtl/series_ctrl.sv | 134 +++++++++++++
 tb/tb_series_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/series_ctrl.sv
// Sequencer for the fixed-point series datapath: ans = 1 + sum c[i]*x^(i+1).
// Optional macro SERIES_CTRL_EARLY_EXIT_EN adds a CHECK state for threshold exit.
module series_ctrl #(
   parameter int TERMS    = 8,
   parameter bit ALT_SIGN = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       less_cmp,
   output logic       busy,
   output logic       done,
   output logic       early,
   output logic       s1_rom,
   output logic       s1_x,
   output logic       s2_tmp,
   output logic       s2_x,
   output logic [7:0] s3,
   output logic       s4_in,
   output logic       s4_mult,
   output logic       ld_x,
   output logic       ld_y,
   output logic       ld_tmp,
   output logic       ld_ans,
   output logic       init_tmp,
   output logic       init_ans,
   output logic       sub
);

`ifdef SERIES_CTRL_EARLY_EXIT_EN
   typedef enum logic [2:0] {IDLE, LOAD, MUL_X, MUL_C, CHECK, ACC, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, LOAD, MUL_X, MUL_C, ACC, DONE} state_t;
`endif

   localparam logic [7:0] LAST_IDX = 8'(TERMS - 1);

   state_t     state;
   state_t     next;
   logic [7:0] idx;
   logic       last;
   logic       accept;
   logic       init_q;

   assign last   = (idx == LAST_IDX);
   assign accept = (state == IDLE) && start;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= next;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     idx <= '0;
      else if (accept)                idx <= '0;
      else if (state == ACC && !last) idx <= idx + 8'd1;
   end

   // Presets drive async inputs in the datapath, so they come straight from a flop.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) init_q <= 1'b0;
      else        init_q <= accept;
   end

`ifdef SERIES_CTRL_EARLY_EXIT_EN
   logic early_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           early_q <= 1'b0;
      else if (accept)                      early_q <= 1'b0;
      else if (state == CHECK && less_cmp)  early_q <= 1'b1;
   end
   assign early = early_q;
`else
   logic unused_less;
   assign unused_less = less_cmp;
   assign early       = 1'b0;
`endif

   always_comb begin
      next = state;
      case (state)
         IDLE:  if (start) next = LOAD;
         LOAD:  next = MUL_X;
         MUL_X: next = MUL_C;
`ifdef SERIES_CTRL_EARLY_EXIT_EN
         MUL_C: next = CHECK;
         CHECK: next = less_cmp ? DONE : ACC;
`else
         MUL_C: next = ACC;
`endif
         ACC:   next = last ? DONE : MUL_X;
         DONE:  next = IDLE;
         default: next = IDLE;
      endcase
   end

   always_comb begin
      s1_rom = 1'b0;
      s2_x   = 1'b0;
      s4_in  = 1'b0;
      s3     = idx;
      ld_x   = 1'b0;
      ld_y   = 1'b0;
      ld_tmp = 1'b0;
      ld_ans = 1'b0;
      sub    = 1'b0;
      case (state)
         LOAD: begin
            s4_in = 1'b1;
            ld_x  = 1'b1;
            ld_y  = 1'b1;
         end
         MUL_X: ld_tmp = 1'b1;
         MUL_C: begin
            s1_rom = 1'b1;
            ld_tmp = 1'b1;
         end
         ACC: begin
            ld_ans = 1'b1;
            sub    = ALT_SIGN && idx[0];
         end
         default: ;
      endcase
   end

   assign s1_x     = ~s1_rom;
   assign s2_tmp   = ~s2_x;
   assign s4_mult  = ~s4_in;
   assign init_tmp = init_q;
   assign init_ans = init_q;
   assign busy     = (state != IDLE);
   assign done     = (state == DONE);

endmodule

// File: tb/tb_series_ctrl.sv
// Bench for series_ctrl: per-cycle expected output vectors are queued per run and
// compared each cycle against two instances (ALT_SIGN 0 and 1).
module tb_series_ctrl;

   localparam int T = 4;
`ifdef SERIES_CTRL_EARLY_EXIT_EN
   localparam bit MAC = 1'b1;
`else
   localparam bit MAC = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic less_cmp = 1'b0;

   logic busy0, done0, early0, s1_rom0, s1_x0, s2_tmp0, s2_x0, s4_in0, s4_mult0;
   logic ld_x0, ld_y0, ld_tmp0, ld_ans0, init_tmp0, init_ans0, sub0;
   logic [7:0] s3_0;
   logic busy1, done1, early1, s1_rom1, s1_x1, s2_tmp1, s2_x1, s4_in1, s4_mult1;
   logic ld_x1, ld_y1, ld_tmp1, ld_ans1, init_tmp1, init_ans1, sub1;
   logic [7:0] s3_1;

   series_ctrl #(.TERMS(T), .ALT_SIGN(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start), .less_cmp(less_cmp),
      .busy(busy0), .done(done0), .early(early0), .s1_rom(s1_rom0), .s1_x(s1_x0),
      .s2_tmp(s2_tmp0), .s2_x(s2_x0), .s3(s3_0), .s4_in(s4_in0), .s4_mult(s4_mult0),
      .ld_x(ld_x0), .ld_y(ld_y0), .ld_tmp(ld_tmp0), .ld_ans(ld_ans0),
      .init_tmp(init_tmp0), .init_ans(init_ans0), .sub(sub0));

   series_ctrl #(.TERMS(T), .ALT_SIGN(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start), .less_cmp(less_cmp),
      .busy(busy1), .done(done1), .early(early1), .s1_rom(s1_rom1), .s1_x(s1_x1),
      .s2_tmp(s2_tmp1), .s2_x(s2_x1), .s3(s3_1), .s4_in(s4_in1), .s4_mult(s4_mult1),
      .ld_x(ld_x1), .ld_y(ld_y1), .ld_tmp(ld_tmp1), .ld_ans(ld_ans1),
      .init_tmp(init_tmp1), .init_ans(init_ans1), .sub(sub1));

   always #5 clk = ~clk;

   // {busy,done,early,s1_rom,s1_x,s2_tmp,s2_x,s4_in,s4_mult,ld_x,ld_y,ld_tmp,ld_ans,init_tmp,init_ans,sub,s3}
   logic [23:0] v0, v1;
   assign v0 = {busy0, done0, early0, s1_rom0, s1_x0, s2_tmp0, s2_x0, s4_in0, s4_mult0,
                ld_x0, ld_y0, ld_tmp0, ld_ans0, init_tmp0, init_ans0, sub0, s3_0};
   assign v1 = {busy1, done1, early1, s1_rom1, s1_x1, s2_tmp1, s2_x1, s4_in1, s4_mult1,
                ld_x1, ld_y1, ld_tmp1, ld_ans1, init_tmp1, init_ans1, sub1, s3_1};

   typedef struct {
      string       nm;
      logic        st;
      logic        ls;
      logic [23:0] e0;
      logic [23:0] e1;
   } ent_t;

   typedef struct {
      int less_at;
      bit hold;
   } run_t;

   ent_t       q[$];
   int         errs = 0;
   int         checks = 0;
   bit         m_early = 1'b0;
   logic [7:0] m_idx = '0;

   function automatic logic [23:0] mk(input bit busy, input bit done, input bit early,
                                      input bit s1_rom, input bit s4_in, input bit ld_xy,
                                      input bit ld_tmp, input bit ld_ans, input bit init,
                                      input bit sub, input logic [7:0] s3);
      return {busy, done, early, s1_rom, ~s1_rom, 1'b1, 1'b0, s4_in, ~s4_in,
              ld_xy, ld_xy, ld_tmp, ld_ans, init, init, sub, s3};
   endfunction

   task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic push(input string nm, input logic st, input logic ls,
                       input logic [23:0] e0, input logic [23:0] e1);
      ent_t e;
      e.nm = nm; e.st = st; e.ls = ls; e.e0 = e0; e.e1 = e1;
      q.push_back(e);
   endtask

   task automatic idle(input int n, input logic st);
      logic [23:0] e;
      e = mk(0, 0, m_early, 0, 0, 0, 0, 0, 0, 0, m_idx);
      for (int k = 0; k < n; k++) push("idle", st, 1'b0, e, e);
   endtask

   // Expected trace of one run, starting with the IDLE cycle that raises start.
   task automatic gen(input int less_at, input bit hold);
      logic [7:0] ix;
      logic rnd;
      bit stop;
      stop = 1'b0;
      idle(1, 1'b1);
      m_early = 1'b0;
      push("load", hold, 1'b0, mk(1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 8'd0),
                               mk(1, 0, 0, 0, 1, 1, 0, 0, 1, 0, 8'd0));
      for (int i = 0; i < T && !stop; i++) begin
         ix = 8'(i);
         m_idx = ix;
         push("mulx", hold, 1'b0, mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, ix),
                                  mk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0, ix));
         rnd = MAC ? 1'b0 : 1'($urandom_range(0, 1));
         push("mulc", hold, rnd, mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, ix),
                                 mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, ix));
         if (MAC) begin
            push("check", hold, 1'(i == less_at), mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ix),
                                                  mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, ix));
            if (i == less_at) begin
               m_early = 1'b1;
               stop = 1'b1;
            end
         end
         if (!stop) begin
            rnd = MAC ? 1'b0 : 1'($urandom_range(0, 1));
            push("acc", hold, rnd, mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, ix),
                                   mk(1, 0, 0, 0, 0, 0, 0, 1, 0, ix[0], ix));
         end
      end
      push("done", hold, 1'b0, mk(1, 1, m_early, 0, 0, 0, 0, 0, 0, 0, m_idx),
                               mk(1, 1, m_early, 0, 0, 0, 0, 0, 0, 0, m_idx));
   endtask

   task automatic drain();
      ent_t e;
      while (q.size() > 0) begin
         @(posedge clk);
         #1;
         e = q.pop_front();
         chk({e.nm, "/alt0"}, v0, e.e0);
         chk({e.nm, "/alt1"}, v1, e.e1);
         start    = e.st;
         less_cmp = e.ls;
      end
   endtask

   run_t runs[5];
   logic [23:0] rstv;
   int k;

   initial begin
      runs[0] = '{less_at: -1, hold: 1'b0};
      runs[1] = '{less_at:  2, hold: 1'b0};
      runs[2] = '{less_at: -1, hold: 1'b1};
      runs[3] = '{less_at: -1, hold: 1'b0};
      runs[4] = '{less_at:  0, hold: 1'b0};

      rstv = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'd0);
      #3;
      chk("reset/alt0", v0, rstv);
      chk("reset/alt1", v1, rstv);
      @(negedge clk);
      rst_n = 1'b1;
      idle(10, 1'b0);
      drain();

      for (int r = 0; r < 5; r++) begin
         gen(runs[r].less_at, runs[r].hold);
         if (!runs[r].hold) idle(2, 1'b0);
      end
      drain();

      // Abort during MUL_C of idx 2, then a clean full run from idx 0.
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      k = MAC ? 1 + 2 * 4 + 2 : 1 + 2 * 3 + 2;
      repeat (k - 1) @(posedge clk);
      #1;
      chk("abort_mulc", v0, mk(1, 0, 0, 1, 0, 0, 1, 0, 0, 0, 8'd2));
      #1;
      rst_n = 1'b0;
      #1;
      chk("abort_reset/alt0", v0, rstv);
      chk("abort_reset/alt1", v1, rstv);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      m_early = 1'b0;
      m_idx = '0;
      idle(3, 1'b0);
      gen(-1, 1'b0);
      idle(2, 1'b0);
      drain();

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
